// File: rtl/tt_um_mult_2b.sv
// TinyTapeout tile: 2x2 unsigned gate-level multiplier with a sampled result
// register and an 8-bit wrapping accumulator that has a sticky overflow flag.

// Half adder cell used by the partial-product reduction.
module tt_um_mult_2b_ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

module tt_um_mult_2b (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned OPW  = 2;
    localparam int unsigned PW   = 4;
    localparam int unsigned ACCW = 8;

    // Input field decode
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic           smp;
    logic           acc_en;
    logic           acc_clr;

    assign a       = ui_in[1:0];
    assign b       = ui_in[3:2];
    assign smp     = ui_in[4];
    assign acc_en  = ui_in[5];
    assign acc_clr = ui_in[6];

    // Inputs that carry no function in this tile
    logic unused_inputs;
    assign unused_inputs = ^{uio_in, ui_in[7]};

    // Partial products
    logic pp00;
    logic pp10;
    logic pp01;
    logic pp11;

    assign pp00 = a[0] & b[0];
    assign pp10 = a[1] & b[0];
    assign pp01 = a[0] & b[1];
    assign pp11 = a[1] & b[1];

    // Reduction of the partial-product array
    logic p1;
    logic c1;
    logic p2;
    logic p3;

    tt_um_mult_2b_ha u_ha_col1 (
        .a (pp10),
        .b (pp01),
        .s (p1),
        .c (c1)
    );

    tt_um_mult_2b_ha u_ha_col2 (
        .a (pp11),
        .b (c1),
        .s (p2),
        .c (p3)
    );

    logic [PW-1:0] prod;
    assign prod = {p3, p2, p1, pp00};

    // Accumulator adder; the extra top bit is the wrap carry
    logic [ACCW:0] acc_sum;
    logic [ACCW-1:0] acc;
    assign acc_sum = (ACCW+1)'(acc) + (ACCW+1)'(prod);

    // State registers
    logic [PW-1:0] pr;
    logic          vld;
    logic          zero;
    logic          ovf;

    // Sample, accumulate and hold logic; zero flag is tracked alongside the
    // product register so every output comes straight from a flop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pr   <= '0;
            vld  <= 1'b0;
            zero <= 1'b1;
            acc  <= '0;
            ovf  <= 1'b0;
        end else if (ena) begin
            if (smp) begin
                pr   <= prod;
                vld  <= 1'b1;
                zero <= (prod == '0);
            end else begin
                vld  <= 1'b0;
            end
            if (acc_clr) begin
                acc <= '0;
                ovf <= 1'b0;
            end else if (smp && acc_en) begin
                acc <= acc_sum[ACCW-1:0];
                ovf <= ovf | acc_sum[ACCW];
            end
        end
    end

    // Output map
    assign uo_out  = {1'b0, ovf, zero, vld, pr};
    assign uio_out = acc;
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_mult_2b.sv
// Scoreboard bench for tt_um_mult_2b: the driver queues the expected outputs
// for each edge, an independent monitor pops and compares after the edge.
module tb_tt_um_mult_2b;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    tt_um_mult_2b dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    typedef struct {
        int         cyc;
        logic [7:0] uo;
        logic [7:0] uio;
        string      name;
    } exp_t;

    exp_t q[$];
    exp_t mx;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitor: compare every expectation that falls due on this edge
    always @(posedge clk) begin
        #2;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            mx = q.pop_front();
            n_cmp++;
            if (mx.cyc < cyc) begin
                n_bad++;
                $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", mx.name, mx.cyc, cyc);
            end else begin
                if (uo_out !== mx.uo) begin
                    n_bad++;
                    $display("FAIL %s uo_out @%0d: got %h want %h", mx.name, cyc, uo_out, mx.uo);
                end
                n_cmp++;
                if (uio_out !== mx.uio) begin
                    n_bad++;
                    $display("FAIL %s uio_out @%0d: got %h want %h", mx.name, cyc, uio_out, mx.uio);
                end
                n_cmp++;
                if (uio_oe !== 8'hFF) begin
                    n_bad++;
                    $display("FAIL %s uio_oe @%0d: got %h want ff", mx.name, cyc, uio_oe);
                end
            end
        end
    end

    function automatic logic [7:0] mk(input int a, input int b, input bit smp,
                                      input bit en, input bit clr);
        return {1'b0, clr, en, smp, 2'(b), 2'(a)};
    endfunction

    function automatic logic [7:0] euo(input int pr, input bit vld, input bit ovf);
        logic [3:0] p;
        p = 4'(pr);
        return {1'b0, ovf, (p == 4'd0), vld, p};
    endfunction

    // Drive one cycle of inputs and queue what must be seen after the edge
    task automatic drive(input logic e, input logic r, input logic [7:0] ui,
                         input logic [7:0] xuo, input logic [7:0] xuio, input string nm);
        exp_t x;
        @(negedge clk);
        ena    = e;
        rst_n  = r;
        ui_in  = ui;
        uio_in = 8'($urandom);
        x.cyc  = cyc + 1;
        x.uo   = xuo;
        x.uio  = xuio;
        x.name = nm;
        q.push_back(x);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        // Reset with random inputs
        drive(1'b1, 1'b0, 8'($urandom), 8'h20, 8'h00, "reset0");
        drive(1'b0, 1'b0, 8'($urandom), 8'h20, 8'h00, "reset1");

        // Exhaustive product table
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                drive(1'b1, 1'b1, mk(a, b, 1, 0, 0), euo(a * b, 1, 0), 8'h00, "prod");

        // Strobe then hold with changing operands
        drive(1'b1, 1'b1, mk(3, 2, 1, 0, 0), euo(6, 1, 0), 8'h00, "hold_smp");
        drive(1'b1, 1'b1, mk(1, 1, 0, 0, 0), euo(6, 0, 0), 8'h00, "hold_drop");
        drive(1'b1, 1'b1, mk(2, 3, 0, 0, 0), euo(6, 0, 0), 8'h00, "hold_keep");

        // ena gating keeps a pending valid and blocks sampling/accumulation
        drive(1'b1, 1'b1, mk(2, 2, 1, 0, 0), euo(4, 1, 0), 8'h00, "gate_pre");
        drive(1'b0, 1'b1, mk(1, 1, 1, 1, 0), euo(4, 1, 0), 8'h00, "gate_off0");
        drive(1'b0, 1'b1, mk(3, 3, 1, 1, 0), euo(4, 1, 0), 8'h00, "gate_off1");
        drive(1'b1, 1'b1, mk(1, 1, 0, 1, 0), euo(4, 0, 0), 8'h00, "gate_on");

        // Accumulate 9 per edge: 252 after 28 adds, wrap to 5 with overflow on 29th
        for (int k = 1; k <= 29; k++)
            drive(1'b1, 1'b1, mk(3, 3, 1, 1, 0), euo(9, 1, k == 29),
                  8'((9 * k) % 256), (k == 28) ? "acc_252" : (k == 29) ? "acc_wrap" : "acc");
        drive(1'b1, 1'b1, mk(3, 3, 0, 1, 0), euo(9, 0, 1), 8'd5, "acc_en_no_smp");
        drive(1'b1, 1'b1, mk(0, 0, 0, 0, 0), euo(9, 0, 1), 8'd5, "ovf_sticky");

        // Clear wins over add while sampling still happens
        drive(1'b1, 1'b1, mk(3, 3, 1, 1, 1), euo(9, 1, 0), 8'h00, "clr_prio");
        drive(1'b1, 1'b1, mk(2, 3, 1, 1, 0), euo(6, 1, 0), 8'd6, "acc_after_clr");
        drive(1'b0, 1'b1, mk(3, 3, 1, 1, 0), euo(6, 1, 0), 8'd6, "acc_gated");

        // Reset mid-accumulation, and reset overriding ena=0
        drive(1'b1, 1'b0, mk(3, 3, 1, 1, 0), 8'h20, 8'h00, "reset_mid");
        drive(1'b1, 1'b1, mk(1, 1, 1, 1, 0), euo(1, 1, 0), 8'd1, "acc_one");
        drive(1'b0, 1'b0, mk(3, 3, 1, 1, 0), 8'h20, 8'h00, "reset_no_ena");
        drive(1'b1, 1'b1, mk(0, 3, 1, 1, 0), euo(0, 1, 0), 8'h00, "zero_prod");

        repeat (3) @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
